uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of P_DATA and bits per frame.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 P_DATA  in  DATA_WIDTH  parallel byte, used only for parity computation at acceptance.
REQ-005 DATA_VALID  in  1  request to transmit P_DATA; honoured only in IDLE.
REQ-006 PAR_EN  in  1  1 = append parity bit.
REQ-007 PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-008 ser_done  in  1  serializer flag: last data bit is on ser_data in this cycle.
REQ-009 ser_data  in  1  serializer bit output.
REQ-010 SER_EN  out  1  serializer shift/count enable.
REQ-011 MUX_SEL  out  2  line source: 00 start, 01 stop/idle, 10 ser_data, 11 parity.
REQ-012 Busy  out  1  frame in progress; serializer loads only when Busy=0.
REQ-013 TX_OUT  out  1  serial line.
REQ-014 TX_DONE  out  1  one-cycle pulse at frame completion.

Function
REQ-015 The block SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: TX_OUT=1, MUX_SEL=01, SER_EN=0, Busy=0; DATA_VALID=1 -> START next edge.
REQ-017 On acceptance (IDLE and DATA_VALID=1), the block SHALL register PAR_EN, PAR_TYP and parity bit = (^P_DATA) ^ PAR_TYP; later changes to these inputs SHALL NOT affect the frame in flight.
REQ-018 START: one cycle, TX_OUT=0, MUX_SEL=00, SER_EN=0, Busy=1; -> DATA unconditionally.
REQ-019 DATA: TX_OUT=ser_data, MUX_SEL=10, SER_EN=1, Busy=1; stays while ser_done=0.
REQ-020 DATA with ser_done=1: -> PARITY if latched PAR_EN=1, else -> STOP; DATA therefore lasts exactly DATA_WIDTH cycles with a compliant serializer.
REQ-021 PARITY: one cycle, TX_OUT=latched parity bit, MUX_SEL=11, SER_EN=0, Busy=1; -> STOP.
REQ-022 STOP: one cycle, TX_OUT=1, MUX_SEL=01, SER_EN=0, Busy=1; TX_DONE=1; -> IDLE.
REQ-023 DATA_VALID in any state other than IDLE SHALL be ignored (no queueing, no state change).
REQ-024 Minimum frame-to-frame spacing SHALL be one IDLE cycle; frame length = DATA_WIDTH+2 cycles (+1 with parity).
REQ-025 TX_OUT, MUX_SEL, SER_EN, Busy, TX_DONE SHALL be decoded from current state only (plus ser_data passthrough in DATA); no combinational path from DATA_VALID to any output.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 RST=0 SHALL force IDLE immediately, regardless of CLK.
REQ-028 Reset values: TX_OUT=1, MUX_SEL=01, SER_EN=0, Busy=0, TX_DONE=0, latched PAR_EN/PAR_TYP/parity=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no TX_DONE; first edge after release with DATA_VALID=1 starts a new frame.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=0, pulse DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy=1 for 10 cycles; TX_DONE pulse in the stop cycle.
REQ-031 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity cycle TX_OUT=0, MUX_SEL=11; PAR_TYP=1 -> TX_OUT=1; Busy=1 for 11 cycles.
REQ-032 P_DATA=0x3C accepted, then P_DATA=0xFF, PAR_TYP toggled and DATA_VALID held high through the frame -> line carries 0x3C with original parity; next frame starts only after one IDLE cycle.
REQ-033 RST pulsed low during the 4th DATA cycle -> TX_OUT=1, Busy=0, SER_EN=0 immediately; no TX_DONE; following DATA_VALID with 0x00 yields a clean 10-cycle frame.
REQ-034 Back-to-back DATA_VALID held high continuously with PAR_EN=0 -> frames of 10 Busy cycles separated by exactly one IDLE cycle; SER_EN high exactly 8 cycles per frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : Moore FSM sequencing a UART frame (start, data, optional
//               parity, stop) around an external serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  SER_EN,
    output logic [1:0]            MUX_SEL,
    output logic                  Busy,
    output logic                  TX_OUT,
    output logic                  TX_DONE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   par_en_q, par_en_d;
    logic   par_bit_q, par_bit_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Frame options are captured only at acceptance so input changes
    // during a frame cannot disturb it.
    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
                    state_d   = S_START;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                end
            end
            S_START:  state_d = S_DATA;
            S_DATA: begin
                if (ser_done) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        TX_OUT  = 1'b1;
        MUX_SEL = 2'b01;
        SER_EN  = 1'b0;
        Busy    = 1'b0;
        TX_DONE = 1'b0;
        case (state_q)
            S_START: begin
                TX_OUT  = 1'b0;
                MUX_SEL = 2'b00;
                Busy    = 1'b1;
            end
            S_DATA: begin
                TX_OUT  = ser_data;
                MUX_SEL = 2'b10;
                SER_EN  = 1'b1;
                Busy    = 1'b1;
            end
            S_PARITY: begin
                TX_OUT  = par_bit_q;
                MUX_SEL = 2'b11;
                Busy    = 1'b1;
            end
            S_STOP: begin
                Busy    = 1'b1;
                TX_DONE = 1'b1;
            end
            default: begin
                TX_OUT  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Directed self-checking bench for uart_tx_ctrl with a
//               behavioural LSB-first serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       ser_data;
    logic       SER_EN;
    logic [1:0] MUX_SEL;
    logic       Busy;
    logic       TX_OUT;
    logic       TX_DONE;

    int checks   = 0;
    int failures = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done),
        .ser_data(ser_data), .SER_EN(SER_EN), .MUX_SEL(MUX_SEL),
        .Busy(Busy), .TX_OUT(TX_OUT), .TX_DONE(TX_DONE)
    );

    always #5 CLK = ~CLK;

    // Serializer: loads whenever Busy is low, shifts LSB first while enabled
    logic [7:0] sh;
    int         cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh  <= 8'h00;
            cnt <= 0;
        end else if (!Busy) begin
            sh  <= P_DATA;
            cnt <= 0;
        end else if (SER_EN) begin
            sh  <= sh >> 1;
            cnt <= cnt + 1;
        end
    end
    assign ser_data = sh[0];
    assign ser_done = SER_EN && (cnt == 7);

    logic       cap_tx [0:19];
    logic [1:0] cap_mux[0:19];
    int cap_len, cap_ser, cap_ndone, cap_done_idx;

    task automatic capture();
        int i = 0;
        cap_ser = 0; cap_ndone = 0; cap_done_idx = -1;
        while (Busy === 1'b1 && i < 20) begin
            cap_tx[i]  = TX_OUT;
            cap_mux[i] = MUX_SEL;
            if (SER_EN) cap_ser++;
            if (TX_DONE) begin
                cap_ndone++;
                cap_done_idx = i;
            end
            i++;
            @(negedge CLK);
        end
        cap_len = i;
    endtask

    function automatic logic [19:0] packed_tx();
        logic [19:0] v = '0;
        for (int k = 0; k < cap_len; k++) v = (v << 1) | {19'd0, cap_tx[k]};
        return v;
    endfunction

    task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #3;
        checks++;
        if ({TX_OUT, MUX_SEL, SER_EN, Busy, TX_DONE} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=101000", {TX_OUT, MUX_SEL, SER_EN, Busy, TX_DONE});
        end
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b tx=%b want busy=0 tx=1", Busy, TX_OUT);
        end
    endtask

    task automatic test_no_parity();
        launch(8'hA5, 1'b0, 1'b0);
        capture();
        checks++;
        if (packed_tx() !== 20'b0101001011) begin
            failures++;
            $display("FAIL a5_line got=%b len=%0d want=0101001011", packed_tx(), cap_len);
        end
        checks++;
        if (cap_len !== 10 || cap_ser !== 8) begin
            failures++;
            $display("FAIL a5_busy_ser busy=%0d ser=%0d want 10/8", cap_len, cap_ser);
        end
        checks++;
        if (cap_ndone !== 1 || cap_done_idx !== 9) begin
            failures++;
            $display("FAIL a5_done count=%0d idx=%0d want 1/9", cap_ndone, cap_done_idx);
        end
        checks++;
        if (TX_DONE !== 1'b0 || TX_OUT !== 1'b1 || MUX_SEL !== 2'b01) begin
            failures++;
            $display("FAIL a5_idle done=%b tx=%b mux=%b want 0/1/01", TX_DONE, TX_OUT, MUX_SEL);
        end
    endtask

    task automatic test_parity();
        launch(8'hA5, 1'b1, 1'b0);
        capture();
        checks++;
        if (packed_tx() !== 20'b01010010101 || cap_mux[9] !== 2'b11) begin
            failures++;
            $display("FAIL even_parity got=%b mux9=%b want=01010010101/11", packed_tx(), cap_mux[9]);
        end
        checks++;
        if (cap_len !== 11 || cap_done_idx !== 10 || cap_ser !== 8) begin
            failures++;
            $display("FAIL even_len busy=%0d done=%0d ser=%0d want 11/10/8", cap_len, cap_done_idx, cap_ser);
        end
        launch(8'hA5, 1'b1, 1'b1);
        capture();
        checks++;
        if (packed_tx() !== 20'b01010010111 || cap_len !== 11) begin
            failures++;
            $display("FAIL odd_parity got=%b len=%0d want=01010010111/11", packed_tx(), cap_len);
        end
    endtask

    task automatic test_input_isolation();
        int n = 0;
        @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1;
        capture();
        checks++;
        if (packed_tx() !== 20'b00011110001 || cap_len !== 11) begin
            failures++;
            $display("FAIL isolate_line got=%b len=%0d want=00011110001/11", packed_tx(), cap_len);
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL isolate_gap busy=%b want 0", Busy);
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b1 || MUX_SEL !== 2'b00) begin
            failures++;
            $display("FAIL isolate_restart busy=%b mux=%b want 1/00", Busy, MUX_SEL);
        end
        DATA_VALID = 1'b0;
        while (Busy === 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL isolate_second_len got=%0d want=10", n);
        end
    endtask

    task automatic test_reset_midframe();
        int dn = 0;
        launch(8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if ({TX_OUT, MUX_SEL, SER_EN, Busy, TX_DONE} !== 6'b101000) begin
            failures++;
            $display("FAIL midreset_outputs got=%b want=101000", {TX_OUT, MUX_SEL, SER_EN, Busy, TX_DONE});
        end
        repeat (2) begin
            @(negedge CLK);
            if (TX_DONE) dn++;
        end
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            if (TX_DONE) dn++;
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL midreset_done got=%0d want=0", dn);
        end
        launch(8'h00, 1'b0, 1'b0);
        capture();
        checks++;
        if (packed_tx() !== 20'b0000000001 || cap_len !== 10 || cap_done_idx !== 9) begin
            failures++;
            $display("FAIL after_reset_frame got=%b len=%0d done=%0d want=0000000001/10/9",
                     packed_tx(), cap_len, cap_done_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] got_b, exp_b;
        int ser_cnt = 0, done_cnt = 0;
        @(negedge CLK);
        P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge CLK);
            got_b[32-k] = Busy;
            exp_b[32-k] = ((k % 11) != 10);
            if (SER_EN) ser_cnt++;
            if (TX_DONE) done_cnt++;
        end
        DATA_VALID = 1'b0;
        checks++;
        if (got_b !== exp_b) begin
            failures++;
            $display("FAIL b2b_busy got=%b want=%b", got_b, exp_b);
        end
        checks++;
        if (ser_cnt !== 24 || done_cnt !== 3) begin
            failures++;
            $display("FAIL b2b_ser_done ser=%0d done=%0d want 24/3", ser_cnt, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_input_isolation();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
